// File: rtl/chacha_seq_if.sv
// Handshake and control bundle between the ChaCha round sequencer and its host/datapath.
// The slave modport is the sequencer side; the master modport is the host side.
interface chacha_seq_if #(
    parameter int ROUNDS = 20,
    parameter int CTR_W  = 32
);
    localparam int DR_W = (ROUNDS / 2 > 1) ? $clog2(ROUNDS / 2) : 1;

    logic             start;
    logic             abort;
    logic             ctr_ld;
    logic [CTR_W-1:0] ctr_in;
    logic             out_ack;
    logic             ready;
    logic             st_load;
    logic             qr_en;
    logic [2:0]       qr_sel;
    logic [DR_W-1:0]  dbl_round;
    logic             ff_add;
    logic             out_valid;
    logic [CTR_W-1:0] blk_ctr;

    modport master (
        output start, abort, ctr_ld, ctr_in, out_ack,
        input  ready, st_load, qr_en, qr_sel, dbl_round, ff_add, out_valid, blk_ctr
    );

    modport slave (
        input  start, abort, ctr_ld, ctr_in, out_ack,
        output ready, st_load, qr_en, qr_sel, dbl_round, ff_add, out_valid, blk_ctr
    );
endinterface

// File: rtl/chacha_round_seq.sv
// ChaCha block-function sequencer: LOAD, 4*ROUNDS quarter-round steps, feed-forward, output hold.
// Optional feature: define CHACHA_CTR_AUTOINC_EN to bump blk_ctr on each acknowledged block.
module chacha_round_seq #(
    parameter int ROUNDS = 20,
    parameter int CTR_W  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    chacha_seq_if.slave bus
);
    localparam int DR_W = (ROUNDS / 2 > 1) ? $clog2(ROUNDS / 2) : 1;
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(ROUNDS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FEED  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t           state_reg;
    logic             ready_reg;
    logic             st_load_reg;
    logic             qr_en_reg;
    logic             ff_add_reg;
    logic             out_valid_reg;
    logic [2:0]       qr_sel_reg;
    logic [DR_W-1:0]  dbl_round_reg;
    logic [CTR_W-1:0] blk_ctr_reg;

    // Every output is a flop written alongside the state, so nothing combinational reaches the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            ready_reg     <= 1'b1;
            st_load_reg   <= 1'b0;
            qr_en_reg     <= 1'b0;
            ff_add_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            qr_sel_reg    <= '0;
            dbl_round_reg <= '0;
            blk_ctr_reg   <= '0;
        end else if (bus.abort) begin
            // Abort beats every other input and leaves the counter alone.
            state_reg     <= S_IDLE;
            ready_reg     <= 1'b1;
            st_load_reg   <= 1'b0;
            qr_en_reg     <= 1'b0;
            ff_add_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            qr_sel_reg    <= '0;
            dbl_round_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.ctr_ld) begin
                        blk_ctr_reg <= bus.ctr_in;
                    end
                    if (bus.start) begin
                        state_reg   <= S_LOAD;
                        ready_reg   <= 1'b0;
                        st_load_reg <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_reg   <= S_ROUND;
                    st_load_reg <= 1'b0;
                    qr_en_reg   <= 1'b1;
                end
                S_ROUND: begin
                    if (qr_sel_reg == 3'd7) begin
                        qr_sel_reg <= 3'd0;
                        if (dbl_round_reg == DR_LAST) begin
                            state_reg     <= S_FEED;
                            qr_en_reg     <= 1'b0;
                            ff_add_reg    <= 1'b1;
                            dbl_round_reg <= '0;
                        end else begin
                            dbl_round_reg <= dbl_round_reg + 1'b1;
                        end
                    end else begin
                        qr_sel_reg <= qr_sel_reg + 3'd1;
                    end
                end
                S_FEED: begin
                    state_reg     <= S_HOLD;
                    ff_add_reg    <= 1'b0;
                    out_valid_reg <= 1'b1;
                end
                S_HOLD: begin
                    // A start arriving with the ack is dropped: ready only rises after this edge.
                    if (bus.out_ack) begin
                        state_reg     <= S_IDLE;
                        out_valid_reg <= 1'b0;
                        ready_reg     <= 1'b1;
`ifdef CHACHA_CTR_AUTOINC_EN
                        blk_ctr_reg   <= blk_ctr_reg + 1'b1;
`endif
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    ready_reg     <= 1'b1;
                    st_load_reg   <= 1'b0;
                    qr_en_reg     <= 1'b0;
                    ff_add_reg    <= 1'b0;
                    out_valid_reg <= 1'b0;
                    qr_sel_reg    <= '0;
                    dbl_round_reg <= '0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_reg;
    assign bus.st_load   = st_load_reg;
    assign bus.qr_en     = qr_en_reg;
    assign bus.qr_sel    = qr_sel_reg;
    assign bus.dbl_round = dbl_round_reg;
    assign bus.ff_add    = ff_add_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.blk_ctr   = blk_ctr_reg;
endmodule
